// File: rtl/four_bit_seq_divider.sv
// rtl/four_bit_seq_divider.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose: divides A by B using a restoring shift/subtract loop. A start seen in
// IDLE captures the operands. A zero divisor goes straight to DONE. Any other
// divisor runs WIDTH iterations. DONE lasts one cycle, then the FSM returns to IDLE.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin a division; ignored unless the FSM is in IDLE
//   A, B   - dividend, divisor (WIDTH bits)
//   Q, R   - quotient, remainder; registered and held until the next DONE
//   busy   - high in RUN and DONE
//   done   - one-cycle pulse in DONE, when Q/R/dbz are valid
//   dbz    - divide-by-zero flag for the last result
//
// Optional feature: define FOUR_BIT_SEQ_DIVIDER_SIGNED_EN to treat A, B, Q and R
// as two's-complement values. Division then runs on magnitudes and uses
// truncating signs. Latency is the same in both builds.

module four_bit_seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] div_q, div_d;   // captured divisor (magnitude)
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             carry;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             unused_trial_bit;

`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
    logic negq_q, negq_d;   // quotient sign: sign(A) xor sign(B)
    logic negr_q, negr_d;   // remainder follows the sign of the dividend

    // The magnitude of the most-negative value is still correct when it is
    // read as an unsigned WIDTH-bit number.
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;
    assign q_fin = negq_q ? -step_quo : step_quo;
    assign r_fin = negr_q ? -step_rem : step_rem;
`else
    assign a_mag = A;
    assign b_mag = B;
    assign q_fin = step_quo;
    assign r_fin = step_rem;
`endif

    // One restoring step. The carry out of shifted + ~div + 1 is set exactly
    // when shifted >= div. A kept difference is below div, so WIDTH bits hold it.
    assign shifted          = {rem_q, quo_q[WIDTH-1]};
    assign trial            = {1'b0, shifted} + {1'b0, ~{1'b0, div_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign carry            = trial[WIDTH+1];
    assign unused_trial_bit = trial[WIDTH];
    assign step_rem         = carry ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign step_quo         = {quo_q[WIDTH-2:0], carry};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (B == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = a_mag;
                        div_d   = b_mag;
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
                        negq_d  = A[WIDTH-1] ^ B[WIDTH-1];
                        negr_d  = A[WIDTH-1];
`endif
                    end
                end
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CW'(1);
                // The last iteration writes its result straight into the output registers.
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    q_d     = q_fin;
                    r_d     = r_fin;
                    dbz_d   = 1'b0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// tb/tb_four_bit_seq_divider.sv - self-checking bench for four_bit_seq_divider

module tb_four_bit_seq_divider;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic [WIDTH-1:0] Q, R;
    logic             busy, done, dbz;

    always #5 clk = ~clk;

    four_bit_seq_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done), .dbz(dbz)
    );

    int checks   = 0;
    int failures = 0;

    // The reference result packs {dbz, Q, R}.
    function automatic logic [2*WIDTH:0] ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] q, r;
        int sa, sb;
        if (b == '0) return {1'b1, {WIDTH{1'b1}}, a};
`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = WIDTH'(sa / sb);
        r  = WIDTH'(sa % sb);
`else
        sa = int'(a);
        sb = int'(b);
        q  = WIDTH'(sa / sb);
        r  = WIDTH'(sa % sb);
`endif
        return {1'b0, q, r};
    endfunction

    // The model is a cycle count since the accepting edge. The result is due
    // at count 1 for a zero divisor and at count WIDTH+1 otherwise.
    int               m_cnt, m_target;
    logic [2*WIDTH:0] p_res, m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_target <= 0;
            p_res    <= '0;
            m_res    <= '0;
        end else if (m_cnt != 0) begin
            if (m_cnt == m_target) begin
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == m_target) m_res <= p_res;
            end
        end else if (start) begin
            p_res    <= ref_div(A, B);
            m_target <= (B == '0) ? 1 : WIDTH + 1;
            m_cnt    <= 1;
            if (B == '0) m_res <= ref_div(A, B);
        end
    end

    // Directed literal expectations, written by the driver.
    logic             lit_en = 1'b0;
    logic [WIDTH-1:0] lit_q, lit_r;
    logic             lit_dbz;
    int               lit_lat;
    int               drv_timeouts = 0;
    logic             finish_req = 1'b0;
    int               lat_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (finish_req) begin
            chk("no_timeouts", drv_timeouts, 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else begin
            if (busy) lat_cnt++;
            else lat_cnt = 0;
            chk("busy", int'(busy), int'(m_cnt != 0));
            chk("done", int'(done), int'(m_cnt != 0 && m_cnt == m_target));
            chk("Q",    int'(Q),    int'(m_res[2*WIDTH-1:WIDTH]));
            chk("R",    int'(R),    int'(m_res[WIDTH-1:0]));
            chk("dbz",  int'(dbz),  int'(m_res[2*WIDTH]));
            if (done && lit_en) begin
                chk("lit_Q",       int'(Q),   int'(lit_q));
                chk("lit_R",       int'(R),   int'(lit_r));
                chk("lit_dbz",     int'(dbz), int'(lit_dbz));
                chk("lit_latency", lat_cnt,   lit_lat);
            end
        end
    end

    // The caller must be 2 time units after a rising edge, with the DUT idle.
    // mode 0: quiet; 1: random start/A/B noise while busy; 2: one extra start one cycle after acceptance.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int mode,
                         input logic lit, input logic [WIDTH-1:0] lq, input logic [WIDTH-1:0] lr,
                         input logic ldbz, input int llat);
        bit seen;
        seen    = 1'b0;
        lit_en  = lit;
        lit_q   = lq;
        lit_r   = lr;
        lit_dbz = ldbz;
        lit_lat = llat;
        start   = 1'b1;
        A       = a;
        B       = b;
        @(posedge clk); #2;
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        for (int n = 0; n < 4 * WIDTH + 8; n++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #2;
            if (mode == 1) begin
                start = 1'($urandom);
                A     = WIDTH'($urandom);
                B     = WIDTH'($urandom);
            end else if (mode == 2) begin
                start = (n == 0);
                A     = 1;
                B     = 1;
            end
        end
        if (!seen) drv_timeouts++;
        start = (mode == 1) ? 1'($urandom) : 1'b0;
        @(posedge clk); #2;
        start  = 1'b0;
        lit_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;

`ifdef FOUR_BIT_SEQ_DIVIDER_SIGNED_EN
        do_op(4'h9, 4'h2, 0, 1'b1, 4'hD, 4'hF, 1'b0, 5);
        do_op(4'h8, 4'hF, 0, 1'b1, 4'h8, 4'h0, 1'b0, 5);
        do_op(4'h6, 4'hC, 0, 1'b1, 4'hF, 4'h2, 1'b0, 5);
        do_op(4'hB, 4'h0, 0, 1'b1, 4'hF, 4'hB, 1'b1, 1);
`else
        do_op(4'd13, 4'd3, 0, 1'b1, 4'd4,  4'd1, 1'b0, 5);
        do_op(4'd5,  4'd0, 0, 1'b1, 4'd15, 4'd5, 1'b1, 1);
        do_op(4'd2,  4'd9, 0, 1'b1, 4'd0,  4'd2, 1'b0, 5);
        do_op(4'd15, 4'd1, 0, 1'b1, 4'd15, 4'd0, 1'b0, 5);
        do_op(4'd12, 4'd2, 2, 1'b1, 4'd6,  4'd0, 1'b0, 5);
`endif

        // Reset asserted in the second RUN cycle, then a fresh division.
        start = 1'b1;
        A     = 4'd13;
        B     = 4'd3;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        do_op(4'd9, 4'd4, 0, 1'b1, 4'd2, 4'd1, 1'b0, 5);

        for (int i = 0; i < 200; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
            do_op(ra, rb, int'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
        end

        finish_req = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not reach its summary");
        $fatal(1);
    end

endmodule

// File: doc/four_bit_seq_divider.md
FOUR_BIT_SEQ_DIVIDER -- requirements
Module: four_bit_seq_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, setting the operand and result width in bits (legal range 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 The module SHALL have port A, input, WIDTH bits: dividend.
REQ-006 The module SHALL have port B, input, WIDTH bits: divisor.
REQ-007 The module SHALL have port Q, output, WIDTH bits: quotient.
REQ-008 The module SHALL have port R, output, WIDTH bits: remainder.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when Q/R/dbz are valid.
REQ-011 The module SHALL have port dbz, output, 1 bit: divide-by-zero flag for the last result.

Function
REQ-012 The FSM SHALL use three states:
- IDLE -> RUN on start=1 with B!=0.
- IDLE -> DONE on start=1 with B==0.
- RUN -> DONE after exactly WIDTH iterations.
- DONE -> IDLE unconditionally.
REQ-013 A and B SHALL be captured into internal registers on the accepting edge; later changes to A/B SHALL NOT affect the result.
REQ-014 Each RUN cycle SHALL perform one restoring step:
- shift {partial remainder, dividend} left by one bit;
- trial-subtract the divisor as partial + ~divisor + 1 in a WIDTH+1-bit datapath;
- keep the difference and shift in quotient bit 1 when the carry-out is 1, else restore and shift in 0.
REQ-015 Latency: done SHALL assert exactly WIDTH+1 cycles after the accepting edge for B!=0, and exactly 1 cycle after it for B==0.
REQ-016 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-017 done SHALL be high only in DONE.
REQ-018 start SHALL be ignored while busy=1. A start asserted in the same cycle that the FSM is in DONE SHALL also be ignored.
REQ-019 Divide-by-zero SHALL produce Q = all ones, R = A, dbz = 1.
REQ-020 dbz SHALL be 0 for every non-zero divisor.
REQ-021 Q, R and dbz SHALL update only on the edge entering DONE and SHALL hold their values until the next DONE.
REQ-022 Unsigned results SHALL satisfy A = Q*B + R with R < B.

Reset
REQ-023 rst_n=0 SHALL asynchronously force:
- state = IDLE;
- Q = 0, R = 0;
- busy = 0, done = 0, dbz = 0;
- all internal registers = 0.
REQ-024 Reset asserted mid-RUN SHALL abort the division with no done pulse.
REQ-025 The first start accepted after reset deassertion SHALL behave as from a cold reset.

Configuration
REQ-026 With macro FOUR_BIT_SEQ_DIVIDER_SIGNED_EN defined, A, B, Q and R SHALL be two's-complement signed.
- Division SHALL operate on magnitudes.
- Q SHALL be negated when sign(A) xor sign(B).
- R SHALL take the sign of A (truncating division).
- Q SHALL wrap for the most-negative / -1 case, giving Q = most-negative and R = 0.
- Divide-by-zero SHALL still give Q = all ones and R = A.
REQ-027 Without the macro, A, B, Q and R SHALL be unsigned and no sign logic SHALL be synthesized.
REQ-028 Latency SHALL be identical with and without the macro.

Verification (WIDTH=4)
REQ-029 A=13, B=3, start pulse -> done 5 cycles later with Q=4, R=1, dbz=0; busy high throughout.
REQ-030 A=5, B=0, start pulse -> done 1 cycle later with Q=15, R=5, dbz=1.
REQ-031 A=2, B=9 -> Q=0, R=2. A=15, B=1 -> Q=15, R=0.
REQ-032 Start A=12, B=2; two cycles later, start with A=1, B=1 -> second start ignored; result Q=6, R=0; exactly one done pulse.
REQ-033 Start A=13, B=3; rst_n low in RUN cycle 2 -> outputs zero immediately, no done pulse. After release, A=9, B=4 -> Q=2, R=1.
REQ-034 With SIGNED_EN:
- A=-7, B=2 -> Q=-3, R=-1.
- A=-8, B=-1 -> Q=-8, R=0.
- A=6, B=-4 -> Q=-1, R=2.
